wb_fetch_arbiter: RTL and testbench

WB_FETCH_ARBITER -- requirements
Module: wb_fetch_arbiter

---
 rtl/wb_arb_pkg.sv | 13 +
 rtl/wb_fetch_arbiter_rr_pick.sv | 31 +++
 rtl/wb_fetch_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_fetch_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the block-fetch Wishbone arbiter: FSM encoding and
// watchdog counter width.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    localparam int WDOG_W = 8;

endpackage

// File: rtl/wb_fetch_arbiter_rr_pick.sv
// Round-robin search: first asserted request starting one past the last
// served index, wrapping modulo NUM.
module rr_pick #(
    parameter int NUM = 2,
    parameter int IW  = 1
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  last,
    output logic [IW-1:0]  next
);

    int            cand;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        next  = '0;
        found = 1'b0;
        cand  = 0;
        idx   = '0;
        for (int i = 1; i <= NUM; i++) begin
            cand = (int'(last) + i) % NUM;
            idx  = IW'(cand);
            if (!found && req[idx]) begin
                next  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_fetch_arbiter.sv
// Round-robin arbiter letting NUM block-fetch masters share one Wishbone
// slave, with a no-acknowledge watchdog that aborts a stuck cycle.
module wb_fetch_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM     = 2,
    parameter int ABITS   = 5,
    parameter int DBITS   = 32,
    parameter int TIMEOUT = 15,
    parameter int DELAY   = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM-1:0]       m_cyc_i,
    input  logic [NUM-1:0]       m_stb_i,
    input  logic [NUM-1:0]       m_we_i,
    input  logic [NUM-1:0]       m_bst_i,
    input  logic [NUM*ABITS-1:0] m_adr_i,
    input  logic [NUM*DBITS-1:0] m_dat_i,
    output logic [NUM-1:0]       m_ack_o,
    output logic [NUM-1:0]       m_wat_o,
    output logic [NUM-1:0]       m_err_o,
    output logic [DBITS-1:0]     m_dat_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic                 s_bst_o,
    output logic [ABITS-1:0]     s_adr_o,
    output logic [DBITS-1:0]     s_dat_o,
    input  logic                 s_ack_i,
    input  logic                 s_wat_i,
    input  logic                 s_err_i,
    input  logic [DBITS-1:0]     s_dat_i,
    output logic [NUM-1:0]       gnt_o,
    output logic                 busy_o
);

    localparam int IW = $clog2(NUM);

    // DELAY only paces register updates in timed behavioural models; this RTL is zero-delay.
    localparam bit PARAMS_OK = (NUM >= 2) && (NUM <= 4) && (TIMEOUT >= 1) &&
                               (TIMEOUT <= 255) && (DELAY >= 0);
    if (!PARAMS_OK) begin : g_params_out_of_range
    end

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     pick;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [NUM-1:0]    gnt_d;

    rr_pick #(
        .NUM (NUM),
        .IW  (IW)
    ) u_pick (
        .req  (m_cyc_i),
        .last (last_q),
        .next (pick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            gidx_q  <= '0;
            last_q  <= IW'(NUM - 1);
            wdog_q  <= '0;
            gnt_o   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            gnt_o   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        gnt_d   = gnt_o;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_bst_o = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_wat_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        busy_o  = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    state_d     = ST_GRANT;
                    gidx_d      = pick;
                    wdog_d      = '0;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                end
            end
            ST_GRANT: begin
                s_cyc_o          = m_cyc_i[gidx_q];
                s_stb_o          = m_stb_i[gidx_q];
                s_we_o           = m_we_i[gidx_q];
                s_bst_o          = m_bst_i[gidx_q];
                s_adr_o          = m_adr_i[int'(gidx_q)*ABITS +: ABITS];
                s_dat_o          = m_dat_i[int'(gidx_q)*DBITS +: DBITS];
                m_ack_o[gidx_q]  = s_ack_i;
                m_wat_o[gidx_q]  = s_wat_i;
                m_err_o[gidx_q]  = s_err_i;
                m_dat_o          = s_dat_i;
                // Master release wins over the watchdog in the same cycle.
                if (!m_cyc_i[gidx_q]) begin
                    state_d = ST_IDLE;
                    last_d  = gidx_q;
                    gnt_d   = '0;
                end else if (s_ack_i) begin
                    wdog_d = '0;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                    if (wdog_d == WDOG_W'(TIMEOUT)) begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_ABORT: begin
                m_err_o[gidx_q] = m_cyc_i[gidx_q];
                if (!m_cyc_i[gidx_q]) begin
                    state_d = ST_IDLE;
                    last_d  = gidx_q;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_fetch_arbiter.sv
// Bench for wb_fetch_arbiter: a NUM=2/TIMEOUT=15 and a NUM=3/TIMEOUT=4 instance
// share one stimulus stream and are checked against an owner-based model.
module tb_wb_fetch_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  cyc, stb, we, bst;
    logic [14:0] adr;
    logic [95:0] wdat;
    logic        ack, wat, err;
    logic [31:0] rdat;

    logic [1:0]  a_ack, a_wat, a_err, a_gnt;
    logic [31:0] a_mdat, a_sdat;
    logic        a_scyc, a_sstb, a_swe, a_sbst, a_busy;
    logic [4:0]  a_sadr;

    logic [2:0]  b_ack, b_wat, b_err, b_gnt;
    logic [31:0] b_mdat, b_sdat;
    logic        b_scyc, b_sstb, b_swe, b_sbst, b_busy;
    logic [4:0]  b_sadr;

    int tests = 0;
    int fails = 0;

    // Model: owner = granted master or -1, aborted flag, unacked-cycle count, last served
    int mown [2];
    int mlast[2];
    int mwd  [2];
    bit mab  [2];
    int mnum [2] = '{2, 3};
    int mtmo [2] = '{15, 4};

    typedef struct {
        logic [2:0] cyc;
        logic       ack;
        logic [1:0] gnt_a;
        logic [1:0] ack_a;
        logic [2:0] gnt_b;
    } vec_t;
    vec_t       tbl [10];
    logic [2:0] order [4];

    wb_fetch_arbiter #(.NUM(2), .ABITS(5), .DBITS(32), .TIMEOUT(15), .DELAY(3)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .m_cyc_i(cyc[1:0]), .m_stb_i(stb[1:0]), .m_we_i(we[1:0]), .m_bst_i(bst[1:0]),
        .m_adr_i(adr[9:0]), .m_dat_i(wdat[63:0]),
        .m_ack_o(a_ack), .m_wat_o(a_wat), .m_err_o(a_err), .m_dat_o(a_mdat),
        .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe), .s_bst_o(a_sbst),
        .s_adr_o(a_sadr), .s_dat_o(a_sdat),
        .s_ack_i(ack), .s_wat_i(wat), .s_err_i(err), .s_dat_i(rdat),
        .gnt_o(a_gnt), .busy_o(a_busy)
    );

    wb_fetch_arbiter #(.NUM(3), .ABITS(5), .DBITS(32), .TIMEOUT(4), .DELAY(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_bst_i(bst),
        .m_adr_i(adr), .m_dat_i(wdat),
        .m_ack_o(b_ack), .m_wat_o(b_wat), .m_err_o(b_err), .m_dat_o(b_mdat),
        .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe), .s_bst_o(b_sbst),
        .s_adr_o(b_sadr), .s_dat_o(b_sdat),
        .s_ack_i(ack), .s_wat_i(wat), .s_err_i(err), .s_dat_i(rdat),
        .gnt_o(b_gnt), .busy_o(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mown[i]  = -1;
            mlast[i] = mnum[i] - 1;
            mwd[i]   = 0;
            mab[i]   = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        int o;
        int c;
        o = mown[i];
        if (o < 0) begin
            for (int d = 1; d <= mnum[i]; d++) begin
                c = (mlast[i] + d) % mnum[i];
                if (mown[i] < 0 && cyc[c]) begin
                    mown[i] = c;
                    mab[i]  = 1'b0;
                    mwd[i]  = 0;
                end
            end
        end else if (!cyc[o]) begin
            mlast[i] = o;
            mown[i]  = -1;
        end else if (!mab[i]) begin
            if (ack) mwd[i] = 0;
            else begin
                mwd[i]++;
                if (mwd[i] >= mtmo[i]) mab[i] = 1'b1;
            end
        end
    endtask

    task automatic model_exp(input int i, output logic [63:0] g, output logic [63:0] b,
                             output logic [63:0] sb, output logic [63:0] rs,
                             output logic [63:0] md);
        logic [2:0] ea, ew, ee;
        int o;
        bit gr;
        o  = mown[i];
        gr = (o >= 0) && !mab[i];
        g  = (o >= 0) ? (64'd1 << o) : 64'd0;
        b  = (o >= 0) ? 64'd1 : 64'd0;
        ea = '0; ew = '0; ee = '0; sb = '0; md = '0;
        if (gr) begin
            ea[o] = ack;
            ew[o] = wat;
            ee[o] = err;
            sb    = {23'd0, cyc[o], stb[o], we[o], bst[o], adr[o*5 +: 5], wdat[o*32 +: 32]};
            md    = {32'd0, rdat};
        end else if (o >= 0) begin
            ee[o] = cyc[o];
        end
        rs = {55'd0, ee, ew, ea};
    endtask

    task automatic check_all();
        logic [63:0] g, b, sb, rs, md;
        model_exp(0, g, b, sb, rs, md);
        check("a_gnt",  {62'd0, a_gnt}, g);
        check("a_busy", {63'd0, a_busy}, b);
        check("a_sbus", {23'd0, a_scyc, a_sstb, a_swe, a_sbst, a_sadr, a_sdat}, sb);
        check("a_resp", {55'd0, 1'b0, a_err, 1'b0, a_wat, 1'b0, a_ack}, rs);
        check("a_mdat", {32'd0, a_mdat}, md);
        model_exp(1, g, b, sb, rs, md);
        check("b_gnt",  {61'd0, b_gnt}, g);
        check("b_busy", {63'd0, b_busy}, b);
        check("b_sbus", {23'd0, b_scyc, b_sstb, b_swe, b_sbst, b_sadr, b_sdat}, sb);
        check("b_resp", {55'd0, b_err, b_wat, b_ack}, rs);
        check("b_mdat", {32'd0, b_mdat}, md);
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        if (rst_n) begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        cyc = '0; stb = '0; we = '0; bst = '0;
        ack = 1'b0; wat = 1'b0; err = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int cnt;
        int n;
        logic [63:0] ew;

        rst_n = 1'b1;
        cyc = '0; stb = '0; we = '0; bst = '0; adr = '0; wdat = '0;
        ack = 1'b0; wat = 1'b0; err = 1'b0; rdat = 32'hCAFE_0001;
        model_reset();

        tbl[0] = '{3'b011, 1'b0, 2'b00, 2'b00, 3'b000};
        tbl[1] = '{3'b011, 1'b1, 2'b01, 2'b01, 3'b001};
        tbl[2] = '{3'b010, 1'b1, 2'b01, 2'b01, 3'b001};
        tbl[3] = '{3'b011, 1'b0, 2'b00, 2'b00, 3'b000};
        tbl[4] = '{3'b011, 1'b1, 2'b10, 2'b10, 3'b010};
        tbl[5] = '{3'b001, 1'b0, 2'b10, 2'b00, 3'b010};
        tbl[6] = '{3'b011, 1'b0, 2'b00, 2'b00, 3'b000};
        tbl[7] = '{3'b011, 1'b1, 2'b01, 2'b01, 3'b001};
        tbl[8] = '{3'b000, 1'b0, 2'b01, 2'b00, 3'b001};
        tbl[9] = '{3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

        #2 rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // Directed arbitration table from reset
        for (int r = 0; r < 10; r++) begin
            cyc = tbl[r].cyc;
            stb = tbl[r].cyc;
            ack = tbl[r].ack;
            #1;
            check("tbl_gnt_a", {62'd0, a_gnt}, {62'd0, tbl[r].gnt_a});
            check("tbl_ack_a", {62'd0, a_ack}, {62'd0, tbl[r].ack_a});
            check("tbl_gnt_b", {61'd0, b_gnt}, {61'd0, tbl[r].gnt_b});
            step();
        end
        idle(2);

        // 24-beat burst from master 0 with an acknowledge every cycle
        cyc = 3'b001; stb = 3'b001; bst = 3'b001; ack = 1'b0;
        step();
        ack = 1'b1;
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            #1;
            if (k == 0) check("burst_gnt", {62'd0, a_gnt}, 64'd1);
            if (a_ack[0]) cnt++;
            step();
        end
        cyc = '0; stb = '0; bst = '0; ack = 1'b0;
        #1;
        check("burst_busy_drop", {63'd0, a_busy}, 64'd1);
        step();
        check("burst_ack_count", 64'(cnt), 64'd24);
        check("burst_idle", {63'd0, a_busy}, 64'd0);
        idle(2);

        // Watchdog abort on the TIMEOUT=4 instance
        cyc = 3'b001; stb = 3'b001; ack = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            check("to_scyc_grant", {63'd0, b_scyc}, 64'd1);
            step();
        end
        check("to_scyc_abort", {63'd0, b_scyc}, 64'd0);
        check("to_err", {61'd0, b_err}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("to_err_hold", {61'd0, b_err}, 64'd1);
        end
        cyc = '0; stb = '0;
        #1;
        check("to_err_drop", {61'd0, b_err}, 64'd0);
        step();
        check("to_idle", {63'd0, b_busy}, 64'd0);
        idle(2);

        // Stall: ten wait cycles mid-burst with both masters requesting
        cyc = 3'b011; stb = 3'b011; ack = 1'b1;
        step();
        repeat (2) step();
        ack = 1'b0; wat = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            ew = (mown[0] >= 0) ? (64'd1 << mown[0]) : 64'd0;
            check("stall_wat", {62'd0, a_wat}, ew);
            step();
        end
        wat = 1'b0; ack = 1'b1;
        repeat (2) step();
        idle(3);

        // Reset mid-burst, then master-0 priority and 3-way round robin
        cyc = 3'b001; stb = 3'b001; ack = 1'b1;
        repeat (3) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_mid_scyc", {62'd0, a_scyc, b_scyc}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc = 3'b111; stb = 3'b111; ack = 1'b1;
            step();
            n = 0;
            while (b_gnt == 3'b000 && n < 5) begin
                step();
                n++;
            end
            check("rr_order", {61'd0, b_gnt}, {61'd0, order[j]});
            if (j == 0) check("rst_prio_a", {62'd0, a_gnt}, 64'd1);
            step();
            cyc = 3'b111 & ~b_gnt;
            stb = cyc;
            step();
            check("rr_gap", {63'd0, b_busy}, 64'd0);
        end
        idle(4);

        // Randomised traffic against the model
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 3) == 0) cyc[k] = ~cyc[k];
            stb  = 3'($urandom);
            we   = 3'($urandom);
            bst  = 3'($urandom);
            adr  = 15'($urandom);
            wdat = {$urandom, $urandom, $urandom};
            ack  = (c % 200 < 100) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
            wat  = ($urandom_range(0, 1) == 1);
            err  = ($urandom_range(0, 7) == 0);
            rdat = $urandom;
            step();
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
